// File: rtl/logic_gate_pkg.sv
// Shared gate opcodes and a per-bit reduction helper for the gate-pipe family.
// gate_reduce folds up to GATE_MAX_CH operand bits through the selected gate function.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam int GATE_MAX_CH = 32;

    // Reduces bits[ch-1:0] (one bit column across channels); PASS returns channel 0.
    function automatic logic gate_reduce(input logic [GATE_MAX_CH-1:0] bits,
                                         input int unsigned            ch,
                                         input logic [2:0]             op);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic r;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int unsigned i = 0; i < GATE_MAX_CH; i++) begin
            if (i < ch) begin
                r_and = r_and & bits[i];
                r_or  = r_or  | bits[i];
                r_xor = r_xor ^ bits[i];
            end
        end
        case (op)
            OP_AND:  r = r_and;
            OP_OR:   r = r_or;
            OP_XOR:  r = r_xor;
            OP_NAND: r = ~r_and;
            OP_NOR:  r = ~r_or;
            OP_XNOR: r = ~r_xor;
            OP_PASS: r = bits[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One pipeline register stage: data, error flag and valid bit, all gated by a common enable.
module logic_gate_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_err,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_err
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;
    logic             err_d,   err_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (en) begin
            valid_d = d_valid;
            data_d  = d_data;
            err_d   = d_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;
    assign q_err   = err_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined CH-operand gate reduction with a single global advance and valid/ready handshake.
// Define LOGIC_GATE_PIPE_STATS_EN to add saturating stat_beats / stat_errs output counters.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CH     = 2,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [2:0]          in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_err
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    output logic [15:0]         stat_beats,
    output logic [15:0]         stat_errs
`endif
);

    logic             adv;
    logic [WIDTH-1:0] red_data;
    logic             red_err;

    logic             vld_pipe [STAGES+1];
    logic [WIDTH-1:0] dat_pipe [STAGES+1];
    logic             err_pipe [STAGES+1];

    always_comb begin
        logic [GATE_MAX_CH-1:0] col;
        red_data = '0;
        col      = '0;
        for (int b = 0; b < WIDTH; b++) begin
            col = '0;
            for (int k = 0; k < CH; k++) col[k] = in_data[k*WIDTH + b];
            red_data[b] = gate_reduce(col, CH, in_op);
        end
    end

    assign red_err = (in_op == OP_RSVD);

    // Whole pipe moves together; it only freezes when a result is waiting on downstream.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign vld_pipe[0] = in_valid;
    assign dat_pipe[0] = red_data;
    assign err_pipe[0] = red_err;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic_gate_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (adv),
            .d_valid (vld_pipe[s]),
            .d_data  (dat_pipe[s]),
            .d_err   (err_pipe[s]),
            .q_valid (vld_pipe[s+1]),
            .q_data  (dat_pipe[s+1]),
            .q_err   (err_pipe[s+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = dat_pipe[STAGES];
    assign out_err   = err_pipe[STAGES];

`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic        out_hs;
    logic [15:0] beats_d, beats_q;
    logic [15:0] errs_d,  errs_q;

    assign out_hs = out_valid && out_ready;

    always_comb begin
        beats_d = beats_q;
        errs_d  = errs_q;
        if (out_hs && beats_q != 16'hFFFF)            beats_d = beats_q + 16'd1;
        if (out_hs && out_err && errs_q != 16'hFFFF)  errs_d  = errs_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q <= '0;
            errs_q  <= '0;
        end else begin
            beats_q <= beats_d;
            errs_q  <= errs_d;
        end
    end

    assign stat_beats = beats_q;
    assign stat_errs  = errs_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized + directed bench for logic_gate_pipe against a queue-based latency/value model.
module tb_logic_gate_pipe;

    localparam int W = 4, C = 2, S = 2;
    localparam int W2 = 8, C2 = 4, S2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0, out_ready = 1'b0;
    logic [C*W-1:0] in_data = '0;
    logic [2:0]     in_op = '0;
    logic           in_ready, out_valid, out_err;
    logic [W-1:0]   out_data;

    logic             b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic [C2*W2-1:0] b_in_data = '0;
    logic [2:0]       b_in_op = '0;
    logic             b_in_ready, b_out_valid, b_out_err;
    logic [W2-1:0]    b_out_data;

`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic [15:0] stat_beats, stat_errs, b_stat_beats, b_stat_errs;
`endif

    logic_gate_pipe #(.WIDTH(W), .CH(C), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        , .stat_beats(stat_beats), .stat_errs(stat_errs)
`endif
    );

    logic_gate_pipe #(.WIDTH(W2), .CH(C2), .STAGES(S2)) u_dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        , .stat_beats(b_stat_beats), .stat_errs(b_stat_errs)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference reduction over whole words.
    function automatic logic [W-1:0] ref_gate(input logic [C*W-1:0] d, input logic [2:0] op);
        logic [W-1:0] a, o, x;
        a = '1; o = '0; x = '0;
        for (int k = 0; k < C; k++) begin
            a &= d[k*W +: W];
            o |= d[k*W +: W];
            x ^= d[k*W +: W];
        end
        case (op)
            3'd0: return a;
            3'd1: return o;
            3'd2: return x;
            3'd3: return ~a;
            3'd4: return ~o;
            3'd5: return ~x;
            3'd6: return d[W-1:0];
            default: return '0;
        endcase
    endfunction

    // Each entry counts the advancing edges it has seen; it is at the output after S of them.
    typedef struct {
        logic [W-1:0] d;
        logic         e;
        int           cnt;
    } ent_t;
    ent_t mq[$];
    int exp_beats = 0, exp_errs = 0;

    always @(negedge rst_n) begin
        mq.delete();
        exp_beats = 0;
        exp_errs  = 0;
    end

    always @(posedge clk) begin
        bit   eov, adv;
        ent_t ne;
        if (rst_n) begin
            eov = (mq.size() > 0) && (mq[0].cnt == S);
            adv = !eov || out_ready;
            if (eov && out_ready) begin
                exp_beats++;
                if (mq[0].e) exp_errs++;
                void'(mq.pop_front());
            end
            if (adv) foreach (mq[i]) mq[i].cnt++;
            if (in_valid && adv) begin
                ne.d = ref_gate(in_data, in_op);
                ne.e = (in_op == 3'd7);
                ne.cnt = 1;
                mq.push_back(ne);
            end
        end
    end

    always @(negedge clk) begin
        bit eov;
        eov = (mq.size() > 0) && (mq[0].cnt == S);
        chk("out_valid", 32'(out_valid), 32'(eov));
        chk("in_ready", 32'(in_ready), 32'(!eov || out_ready));
        if (eov) begin
            chk("out_data", 32'(out_data), 32'(mq[0].d));
            chk("out_err", 32'(out_err), 32'(mq[0].e));
        end
`ifdef LOGIC_GATE_PIPE_STATS_EN
        chk("stat_beats", 32'(stat_beats), 32'(exp_beats));
        chk("stat_errs", 32'(stat_errs), 32'(exp_errs));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one beat to the narrow DUT, then waits (bounded) for its result.
    task automatic one_beat(input string name, input logic [C*W-1:0] d, input logic [2:0] op,
                            input logic [W-1:0] exp_d, input logic exp_e);
        int lat;
        in_data = d; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin step(); lat++; end
        chk({name, "_lat"}, 32'(lat), 32'(S - 1));
        chk({name, "_data"}, 32'(out_data), 32'(exp_d));
        chk({name, "_err"}, 32'(out_err), 32'(exp_e));
        step();
    endtask

    task automatic wide_beat(input string name, input logic [2:0] op, input logic [W2-1:0] exp_d);
        int lat;
        b_in_data = {8'h08, 8'h04, 8'h02, 8'h01}; b_in_op = op; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 12) begin step(); lat++; end
        chk({name, "_lat"}, 32'(lat), 32'(S2 - 1));
        chk({name, "_data"}, 32'(b_out_data), 32'(exp_d));
        step();
    endtask

    logic [W-1:0] tt [7] = '{4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 4'b1001, 4'b0011};

    initial begin
        logic [W-1:0] held;
        int vcnt, first, last;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        one_beat("rsvd", 8'hFF, 3'd7, 4'h0, 1'b1);
`ifdef LOGIC_GATE_PIPE_STATS_EN
        chk("rsvd_stat_beats", 32'(stat_beats), 32'd1);
        chk("rsvd_stat_errs", 32'(stat_errs), 32'd1);
`endif

        for (int op = 0; op < 7; op++)
            one_beat($sformatf("tt_op%0d", op), {4'b0101, 4'b0011}, 3'(op), tt[op], 1'b0);

        // Throughput: 8 back-to-back beats should leave as 8 consecutive results.
        out_ready = 1'b1;
        vcnt = 0; first = -1; last = -1;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                in_valid = 1'b1; in_data = 8'($urandom); in_op = 3'($urandom_range(0, 6));
                chk("tput_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                vcnt++;
                if (first < 0) first = t;
                last = t;
            end
            step();
        end
        chk("tput_count", 32'(vcnt), 32'd8);
        chk("tput_contig", 32'(last - first), 32'd7);

        // Backpressure: fill the pipe, hold for 5 cycles, then release.
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_op = 3'($urandom_range(0, 7));
            step();
        end
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        held = out_data;
        repeat (5) step();
        chk("bp_stable", 32'(out_data), 32'(held));
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (S + 3) step();
        chk("bp_drained", 32'(mq.size()), 32'd0);

        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom);
            in_op     = 3'($urandom_range(0, 7));
            step();
        end

        // Reset in the middle of traffic.
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_err", 32'(out_err), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (S + 2) step();
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        wide_beat("wide_xor", 3'd2, 8'h0F);
        wide_beat("wide_and", 3'd0, 8'h00);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
